// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq
//  Brief    : Reset sequencer. Synchronizes release of the system reset into
//             clk, releases NDOM peripheral reset domains in order 0..NDOM-1
//             with a programmable per-domain delay, then serves software
//             per-domain reset requests with a fixed-length pulse and ack.
//  Revision : 1.0 - initial release
// ============================================================================
module rst_seq #(
    parameter int NDOM        = 4,
    parameter int DLY_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NDOM*DLY_W-1:0] dly,
    input  logic [NDOM-1:0]       sw_rst_req,
    output logic [NDOM-1:0]       dom_rst_n,
    output logic                  seq_done,
    output logic [NDOM-1:0]       sw_rst_ack
);

    localparam int IDX_W  = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NDOM - 1);
    localparam logic [PCNT_W-1:0] PCNT_INIT = PCNT_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SEQ   = 2'd1,
        DONE  = 2'd2,
        SWRST = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   srel;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [DLY_W-1:0]       cnt, cnt_nxt;
    logic [PCNT_W-1:0]      pcnt, pcnt_nxt;
    logic [NDOM-1:0]        act, act_nxt;
    logic [NDOM-1:0]        pending, pending_nxt;
    logic [NDOM-1:0]        dom_nxt;
    logic                   done_nxt;
    logic [NDOM-1:0]        ack_nxt;
    logic [DLY_W-1:0]       dly_arr [NDOM];

    // Split the packed delay bus into one field per domain
    generate
        for (genvar gi = 0; gi < NDOM; gi++) begin : g_dly
            assign dly_arr[gi] = dly[gi*DLY_W +: DLY_W];
        end
    endgenerate

    // Reset-release synchronizer: asserts asynchronously, releases after SYNC_STAGES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign srel = sync[SYNC_STAGES-1];

    // State and datapath registers; every output comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            idx        <= '0;
            cnt        <= '0;
            pcnt       <= '0;
            act        <= '0;
            pending    <= '0;
            dom_rst_n  <= '0;
            seq_done   <= 1'b0;
            sw_rst_ack <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            pcnt       <= pcnt_nxt;
            act        <= act_nxt;
            pending    <= pending_nxt;
            dom_rst_n  <= dom_nxt;
            seq_done   <= done_nxt;
            sw_rst_ack <= ack_nxt;
        end
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        pcnt_nxt    = pcnt;
        act_nxt     = act;
        pending_nxt = pending | sw_rst_req;
        dom_nxt     = dom_rst_n;
        done_nxt    = 1'b0;
        ack_nxt     = '0;

        case (state)
            SYNC: begin
                if (srel) begin
                    state_nxt = SEQ;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end

            SEQ: begin
                // Counter stops at the delay value, so it never overflows
                if (cnt == dly_arr[idx]) begin
                    dom_nxt[idx] = 1'b1;
                    cnt_nxt      = '0;
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DONE: begin
                if (pending != '0) begin
                    // All requests latched so far share one pulse; new ones wait
                    act_nxt     = pending;
                    pending_nxt = sw_rst_req;
                    dom_nxt     = dom_rst_n & ~pending;
                    pcnt_nxt    = PCNT_INIT;
                    state_nxt   = SWRST;
                end else begin
                    done_nxt = 1'b1;
                end
            end

            SWRST: begin
                if (pcnt == '0) begin
                    dom_nxt   = dom_rst_n | act;
                    ack_nxt   = act;
                    state_nxt = DONE;
                end else begin
                    pcnt_nxt = pcnt - 1'b1;
                end
            end

            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq
//  Brief    : Self-checking bench for rst_seq: table-driven release sequence
//             traces plus hand-written software-reset and reset-abort cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq;

    localparam int NDOM  = 4;
    localparam int DLY_W = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NDOM*DLY_W-1:0] dly;
    logic [NDOM-1:0]       sw_rst_req;
    logic [NDOM-1:0]       dom_rst_n;
    logic                  seq_done;
    logic [NDOM-1:0]       sw_rst_ack;

    int checks = 0;
    int errs   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] dom;
        logic       done;
        logic [3:0] ack;
    } vec_t;

    vec_t t_def  [15];
    vec_t t_zero [8];

    // Expected dom_rst_n after each edge following reset release
    logic [3:0] def_dom  [15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h3,
                                  4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
    logic [3:0] zero_dom [8]  = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF};

    rst_seq #(
        .NDOM        (NDOM),
        .DLY_W       (DLY_W),
        .SYNC_STAGES (2),
        .PULSE_LEN   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dly        (dly),
        .sw_rst_req (sw_rst_req),
        .dom_rst_n  (dom_rst_n),
        .seq_done   (seq_done),
        .sw_rst_ack (sw_rst_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [3:0] dom, input logic done,
                            input logic [3:0] ack);
        chk({name, " dom"},  32'(dom_rst_n),  32'(dom));
        chk({name, " done"}, 32'(seq_done),   32'(done));
        chk({name, " ack"},  32'(sw_rst_ack), 32'(ack));
    endtask

    task automatic run_tbl(input string tag, input bit zero, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v = zero ? t_zero[i] : t_def[i];
            sw_rst_req = v.req;
            step(1);
            chk_outs($sformatf("%s e%0d", tag, i + 1), v.dom, v.done, v.ack);
        end
        sw_rst_req = '0;
    endtask

    // Expects the pulse for m to start on the next edge; optionally injects a request mid-pulse
    task automatic pulse_check(input string tag, input logic [3:0] m, input int inj_at,
                               input logic [3:0] inj);
        for (int i = 0; i < 16; i++) begin
            sw_rst_req = (i == inj_at) ? inj : 4'h0;
            step(1);
            chk_outs($sformatf("%s low%0d", tag, i), 4'hF & ~m, 1'b0, 4'h0);
        end
        sw_rst_req = '0;
        step(1);
        chk_outs({tag, " release"}, 4'hF, 1'b0, m);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk_outs({tag, " async"}, 4'h0, 1'b0, 4'h0);
        step(2);
        chk_outs({tag, " held"}, 4'h0, 1'b0, 4'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 15; i++) begin
            t_def[i].req  = 4'h0;
            t_def[i].dom  = def_dom[i];
            t_def[i].done = (i >= 13);
            t_def[i].ack  = 4'h0;
        end
        for (int i = 0; i < 8; i++) begin
            t_zero[i].req  = 4'h0;
            t_zero[i].dom  = zero_dom[i];
            t_zero[i].done = (i >= 7);
            t_zero[i].ack  = 4'h0;
        end

        rst_n      = 1'b0;
        dly        = {8'd3, 8'd0, 8'd2, 8'd1};
        sw_rst_req = '0;
        step(3);
        chk_outs("reset", 4'h0, 1'b0, 4'h0);

        // Power-up release sequence with dly = {3,0,2,1}
        rst_n = 1'b1;
        run_tbl("seq", 1'b0, 15);

        // Single software reset of domain 1
        sw_rst_req = 4'b0010;
        step(1);
        sw_rst_req = '0;
        chk_outs("sw1 latch", 4'hF, 1'b1, 4'h0);
        pulse_check("sw1", 4'b0010, -1, 4'h0);
        step(1);
        chk_outs("sw1 after", 4'hF, 1'b1, 4'h0);

        // Re-request during a pulse: second unmerged pulse, 1-cycle DONE gap
        sw_rst_req = 4'b0010;
        step(1);
        sw_rst_req = '0;
        pulse_check("b2b first", 4'b0010, 5, 4'b0110);
        pulse_check("b2b second", 4'b0110, -1, 4'h0);
        step(1);
        chk_outs("b2b after", 4'hF, 1'b1, 4'h0);

        // Request during SEQ is held until DONE, then served as one pulse
        async_reset("rst3");
        t_def[4].req = 4'b1001;
        run_tbl("seqreq", 1'b0, 13);
        t_def[4].req = 4'h0;
        pulse_check("seqreq", 4'b1001, -1, 4'h0);
        step(1);
        chk_outs("seqreq after", 4'hF, 1'b1, 4'h0);

        // Reset mid-SEQ with a pending request: request must be discarded
        async_reset("rst5a pre");
        t_def[2].req = 4'b0100;
        run_tbl("abort", 1'b0, 6);
        t_def[2].req = 4'h0;
        async_reset("rst5a");
        run_tbl("reseq", 1'b0, 15);
        step(3);
        chk_outs("no stale pulse", 4'hF, 1'b1, 4'h0);

        // Reset mid-SWRST, then a full zero-delay sequence
        sw_rst_req = 4'b1000;
        step(1);
        sw_rst_req = '0;
        step(4);
        chk_outs("mid pulse", 4'b0111, 1'b0, 4'h0);
        dly = '0;
        async_reset("rst5b");
        run_tbl("zero", 1'b1, 8);
        step(1);
        chk_outs("zero after", 4'hF, 1'b1, 4'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
